claw_seq_ctrl: RTL

Parametrised game sequencer for the claw machine: counts coin credits, runs a timed play round with per-axis jog commands on N_AXIS gantry axes, then executes a fixed drop / grip / raise claw sequence. Sits between the keyboard/pushbutton front end (Debounce, OnePulse, KeyboardDecoder) and the motor drive (motor, PWM_gen). It replaces the single-axis hard-coded controller with configurable axis count, phase durations, credit banking, play timeout and end-stop limit gating.

---
 rtl/claw_seq_ctrl_if.sv | 31 +++
 rtl/claw_seq_ctrl.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/claw_seq_ctrl_if.sv
// Signal bundle between the claw sequencer and its surroundings: front-end
// strobes and end-stops in, axis/claw drive and status out.
interface claw_seq_ctrl_if #(
    parameter int unsigned N_AXIS = 2
);
    logic                  coin_pulse;
    logic                  cmd_valid;
    logic [N_AXIS-1:0]     cmd_pos;
    logic [N_AXIS-1:0]     cmd_neg;
    logic                  cmd_grab;
    logic [N_AXIS-1:0]     limit_pos;
    logic [N_AXIS-1:0]     limit_neg;
    logic [2*N_AXIS-1:0]   axis_dir;
    logic [1:0]            claw_z;
    logic                  claw_close;
    logic [3:0]            credits;
    logic [2:0]            state_o;
    logic                  round_done;

    modport master (
        output coin_pulse, cmd_valid, cmd_pos, cmd_neg, cmd_grab,
        output limit_pos, limit_neg,
        input  axis_dir, claw_z, claw_close, credits, state_o, round_done
    );

    modport slave (
        input  coin_pulse, cmd_valid, cmd_pos, cmd_neg, cmd_grab,
        input  limit_pos, limit_neg,
        output axis_dir, claw_z, claw_close, credits, state_o, round_done
    );
endinterface

// File: rtl/claw_seq_ctrl.sv
// Claw machine round sequencer: credit banking, timed jog play on N_AXIS
// gantry axes with end-stop gating, then a fixed drop / grip / raise cycle.
//
//   state | meaning
//   IDLE  | waiting for a banked credit, all motion stopped
//   PLAY  | player jogs axes until grab request or play timeout
//   DROP  | claw lowering, gripper open
//   HOLD  | claw at bottom, gripper closed
//   RAISE | claw rising, gripper closed
//   DONE  | single-cycle end-of-round pulse
module claw_seq_ctrl #(
    parameter int unsigned N_AXIS       = 2,
    parameter int unsigned JOG_CYCLES   = 10_000_000,
    parameter int unsigned DROP_CYCLES  = 75_000_000,
    parameter int unsigned HOLD_CYCLES  = 125_000_000,
    parameter int unsigned RAISE_CYCLES = 75_000_000,
    parameter int unsigned PLAY_TIMEOUT = 1_000_000_000,
    parameter int unsigned MAX_CREDIT   = 9
) (
    input  logic           clk,
    input  logic           reset,
    claw_seq_ctrl_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_PLAY  = 3'd1,
        S_DROP  = 3'd2,
        S_HOLD  = 3'd3,
        S_RAISE = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    localparam int unsigned     JW         = $clog2(JOG_CYCLES + 1);
    localparam logic [JW-1:0]   JOG_LOAD   = JW'(JOG_CYCLES);
    localparam logic [31:0]     PLAY_LAST  = 32'(PLAY_TIMEOUT - 1);
    localparam logic [31:0]     DROP_LAST  = 32'(DROP_CYCLES - 1);
    localparam logic [31:0]     HOLD_LAST  = 32'(HOLD_CYCLES - 1);
    localparam logic [31:0]     RAISE_LAST = 32'(RAISE_CYCLES - 1);
    localparam logic [3:0]      CRED_MAX   = 4'(MAX_CREDIT);

    state_t                       state_q, state_d;
    logic [3:0]                   credits_q, credits_d;
    logic [31:0]                  play_timer_q, play_timer_d;
    logic [31:0]                  phase_q, phase_d;
    logic [2*N_AXIS-1:0]          dir_q, dir_d;
    logic [N_AXIS-1:0][JW-1:0]    jog_cnt_q, jog_cnt_d;
    logic [1:0]                   claw_z_q, claw_z_d;
    logic                         claw_close_q, claw_close_d;
    logic                         round_done_q, round_done_d;

    logic                         consume;
    logic [N_AXIS-1:0]            blocked;
    logic [2*N_AXIS-1:0]          axis_dir_gated;

    // An axis driving into its own asserted end-stop is blocked.
    always_comb begin
        blocked = '0;
        for (int i = 0; i < N_AXIS; i++) begin
            blocked[i] = (dir_q[2*i+1] & bus.limit_pos[i]) |
                         (dir_q[2*i]   & bus.limit_neg[i]);
        end
    end

    always_comb begin
        axis_dir_gated = '0;
        for (int i = 0; i < N_AXIS; i++) begin
            axis_dir_gated[2*i +: 2] = blocked[i] ? 2'b00 : dir_q[2*i +: 2];
        end
    end

    // Next state, timers and credits.
    always_comb begin
        state_d = state_q;
        consume = (state_q == S_IDLE) && (credits_q != 4'd0);

        case (state_q)
            S_IDLE:  if (consume) state_d = S_PLAY;
            S_PLAY:  if (bus.cmd_grab || (play_timer_q == PLAY_LAST)) state_d = S_DROP;
            S_DROP:  if (phase_q == DROP_LAST)  state_d = S_HOLD;
            S_HOLD:  if (phase_q == HOLD_LAST)  state_d = S_RAISE;
            S_RAISE: if (phase_q == RAISE_LAST) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        phase_d      = (state_d != state_q) ? 32'd0 : phase_q + 32'd1;
        play_timer_d = (state_q == S_PLAY && state_d == S_PLAY) ? play_timer_q + 32'd1 : 32'd0;

        // A coin landing on the consumption edge cancels out, even when saturated.
        credits_d = credits_q;
        if (bus.coin_pulse && !consume) begin
            if (credits_q < CRED_MAX) credits_d = credits_q + 4'd1;
        end else if (!bus.coin_pulse && consume) begin
            credits_d = credits_q - 4'd1;
        end
    end

    // Per-axis jog direction and run-length counters.
    always_comb begin
        dir_d     = dir_q;
        jog_cnt_d = jog_cnt_q;

        for (int i = 0; i < N_AXIS; i++) begin
            if (jog_cnt_q[i] != '0) jog_cnt_d[i] = jog_cnt_q[i] - 1'b1;
            if (blocked[i])         jog_cnt_d[i] = '0;

            if (bus.cmd_valid) begin
                case ({bus.cmd_pos[i], bus.cmd_neg[i]})
                    2'b10: begin
                        if (!bus.limit_pos[i]) begin
                            dir_d[2*i +: 2] = 2'b10;
                            jog_cnt_d[i]    = JOG_LOAD;
                        end
                    end
                    2'b01: begin
                        if (!bus.limit_neg[i]) begin
                            dir_d[2*i +: 2] = 2'b01;
                            jog_cnt_d[i]    = JOG_LOAD;
                        end
                    end
                    2'b11:   jog_cnt_d[i] = '0;
                    default: ;
                endcase
            end

            if (jog_cnt_d[i] == '0) dir_d[2*i +: 2] = 2'b00;
        end

        // Jogging exists only while staying in PLAY; grab or timeout wins over commands.
        if (state_q != S_PLAY || state_d != S_PLAY) begin
            dir_d     = '0;
            jog_cnt_d = '0;
        end
    end

    // Claw outputs are registered against the state being entered.
    always_comb begin
        claw_z_d     = 2'b00;
        claw_close_d = 1'b0;
        round_done_d = 1'b0;
        case (state_d)
            S_DROP:  claw_z_d = 2'b01;
            S_HOLD:  claw_close_d = 1'b1;
            S_RAISE: begin
                claw_z_d     = 2'b10;
                claw_close_d = 1'b1;
            end
            S_DONE:  round_done_d = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            credits_q    <= 4'd0;
            play_timer_q <= 32'd0;
            phase_q      <= 32'd0;
            dir_q        <= '0;
            jog_cnt_q    <= '0;
            claw_z_q     <= 2'b00;
            claw_close_q <= 1'b0;
            round_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            credits_q    <= credits_d;
            play_timer_q <= play_timer_d;
            phase_q      <= phase_d;
            dir_q        <= dir_d;
            jog_cnt_q    <= jog_cnt_d;
            claw_z_q     <= claw_z_d;
            claw_close_q <= claw_close_d;
            round_done_q <= round_done_d;
        end
    end

    assign bus.axis_dir   = axis_dir_gated;
    assign bus.claw_z     = claw_z_q;
    assign bus.claw_close = claw_close_q;
    assign bus.credits    = credits_q;
    assign bus.state_o    = state_q;
    assign bus.round_done = round_done_q;
endmodule
